// File: rtl/traffic_light_sequencer_if.sv
// traffic_light_sequencer_if
//   Bundles the sequencer's timer-side and lamp-side signals.
//   master: drives tick, sensor, walk request, reprogram strobe and timer value
//           (timer block / environment side).
//   slave : the sequencer; drives interval select, lamp codes, walk and expired.
//   Signals:
//     one_hz_en   1  single-cycle tick, one per second
//     sensor      1  farm-road vehicle present
//     walk_req    1  pedestrian button
//     prog_sync   1  timer reprogram strobe
//     value       4  seconds for the selected interval
//     interval    2  interval select to the timer block
//     hwy_lights  3  {R,Y,G} one-hot
//     farm_lights 3  {R,Y,G} one-hot
//     walk        1  pedestrian walk lamp
//     expired     1  one-cycle pulse when a countdown ends
interface traffic_light_sequencer_if;
  logic       one_hz_en;
  logic       sensor;
  logic       walk_req;
  logic       prog_sync;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] hwy_lights;
  logic [2:0] farm_lights;
  logic       walk;
  logic       expired;

  modport master (
    output one_hz_en, sensor, walk_req, prog_sync, value,
    input  interval, hwy_lights, farm_lights, walk, expired
  );

  modport slave (
    input  one_hz_en, sensor, walk_req, prog_sync, value,
    output interval, hwy_lights, farm_lights, walk, expired
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer
//   Main intersection FSM for a highway / farm-road crossing with an optional
//   pedestrian phase. Each state first spends LOAD_WAIT cycles with its
//   interval select held so the timer block can settle, then loads the
//   returned second count and counts it down on the 1 Hz enable.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    traffic_light_sequencer_if.slave (tick, sensor, walk_req,
//            prog_sync, value in; interval, lamps, walk, expired out)
//   Parameters:
//     LOAD_WAIT  cycles from interval change until value is sampled
//   Build option:
//     PED_WALK_EN  enables the pedestrian WK phase, walk_pend and walk lamp.
//
//   state | meaning
//   HG    | highway green, farm red (interval 11); waits for demand after expiry
//   HY    | highway yellow, farm red (interval 10)
//   FG    | farm green, highway red (00, or 01 for the single extension)
//   FY    | farm yellow, highway red (interval 10)
//   WK    | both red, walk lamp on (interval 01)
module traffic_light_sequencer #(
  parameter int LOAD_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_light_sequencer_if.slave bus
);

  localparam int LCW = (LOAD_WAIT > 2) ? $clog2(LOAD_WAIT) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_WAIT - 1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [1:0] IV_BASE   = 2'b00;
  localparam logic [1:0] IV_EXTEND = 2'b01;
  localparam logic [1:0] IV_YELLOW = 2'b10;
  localparam logic [1:0] IV_DOUBLE = 2'b11;

  typedef enum logic [2:0] {ST_HG, ST_HY, ST_FG, ST_FY, ST_WK} state_t;
  typedef enum logic {PH_LOAD, PH_RUN} phase_t;

  state_t         state,     state_nxt, target;
  phase_t         phase,     phase_nxt;
  logic [LCW-1:0] load_cnt,  load_cnt_nxt;
  logic [3:0]     counter,   counter_nxt;
  logic           ext_used,  ext_nxt;
  logic           walk_pend, pend_nxt;
  logic           hg_wait,   wait_nxt;
  logic           go;
  logic           demand;
  logic           walk_set;

  logic [1:0]     interval_q,  interval_nxt;
  logic [2:0]     hwy_q,       hwy_nxt;
  logic [2:0]     farm_q,      farm_nxt;
  logic           walk_q,      walk_nxt;
  logic           expired_q,   expired_nxt;

`ifdef PED_WALK_EN
  localparam logic PED = 1'b1;
  assign walk_set = bus.walk_req && (state != ST_WK);
`else
  localparam logic PED = 1'b0;
  logic unused_walk_req;
  assign unused_walk_req = bus.walk_req;
  assign walk_set        = 1'b0;
`endif

  assign demand = bus.sensor | walk_pend;

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    load_cnt_nxt = load_cnt;
    counter_nxt  = counter;
    ext_nxt      = ext_used;
    pend_nxt     = walk_pend;
    wait_nxt     = hg_wait;
    expired_nxt  = 1'b0;
    go           = 1'b0;
    target       = state;

    if (bus.prog_sync) begin
      state_nxt    = ST_HG;
      phase_nxt    = PH_LOAD;
      load_cnt_nxt = '0;
      counter_nxt  = '0;
      ext_nxt      = 1'b0;
      pend_nxt     = 1'b0;
      wait_nxt     = 1'b0;
    end else begin
      pend_nxt = walk_pend | walk_set;
      if (phase == PH_LOAD) begin
        // ticks arriving here are dropped on purpose
        if (load_cnt == LOAD_LAST) begin
          phase_nxt   = PH_RUN;
          counter_nxt = (bus.value == 4'd0) ? 4'd1 : bus.value;
        end else begin
          load_cnt_nxt = load_cnt + LCW'(1);
        end
      end else if (state == ST_HG && hg_wait) begin
        // countdown already ended; leave as soon as anyone is waiting
        if (demand) begin
          go     = 1'b1;
          target = ST_HY;
        end
      end else if (bus.one_hz_en) begin
        if (counter > 4'd1) begin
          counter_nxt = counter - 4'd1;
        end else begin
          expired_nxt = 1'b1;
          case (state)
            ST_HG: begin
              if (demand) begin
                go     = 1'b1;
                target = ST_HY;
              end else begin
                wait_nxt = 1'b1;
              end
            end
            ST_HY: begin
              go     = 1'b1;
              target = walk_pend ? ST_WK : ST_FG;
            end
            ST_FG: begin
              go = 1'b1;
              if (bus.sensor && !ext_used) begin
                target  = ST_FG;
                ext_nxt = 1'b1;
              end else begin
                target  = ST_FY;
                ext_nxt = 1'b0;
              end
            end
            ST_FY: begin
              go     = 1'b1;
              target = ST_HG;
            end
            ST_WK: begin
              go       = 1'b1;
              pend_nxt = 1'b0;
              target   = bus.sensor ? ST_FG : ST_HG;
            end
            default: begin
              go     = 1'b1;
              target = ST_HG;
            end
          endcase
        end
      end

      if (go) begin
        state_nxt    = target;
        phase_nxt    = PH_LOAD;
        load_cnt_nxt = '0;
        wait_nxt     = 1'b0;
      end
    end
  end

  // Output decode from the next state so lamps switch on the state edge.
  always_comb begin
    interval_nxt = IV_DOUBLE;
    hwy_nxt      = LAMP_G;
    farm_nxt     = LAMP_R;
    walk_nxt     = 1'b0;
    case (state_nxt)
      ST_HY: begin
        interval_nxt = IV_YELLOW;
        hwy_nxt      = LAMP_Y;
      end
      ST_FG: begin
        interval_nxt = ext_nxt ? IV_EXTEND : IV_BASE;
        hwy_nxt      = LAMP_R;
        farm_nxt     = LAMP_G;
      end
      ST_FY: begin
        interval_nxt = IV_YELLOW;
        hwy_nxt      = LAMP_R;
        farm_nxt     = LAMP_Y;
      end
      ST_WK: begin
        interval_nxt = IV_EXTEND;
        hwy_nxt      = LAMP_R;
        walk_nxt     = PED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HG;
      phase      <= PH_LOAD;
      load_cnt   <= '0;
      counter    <= '0;
      ext_used   <= 1'b0;
      walk_pend  <= 1'b0;
      hg_wait    <= 1'b0;
      interval_q <= IV_DOUBLE;
      hwy_q      <= LAMP_G;
      farm_q     <= LAMP_R;
      walk_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      load_cnt   <= load_cnt_nxt;
      counter    <= counter_nxt;
      ext_used   <= ext_nxt;
      walk_pend  <= pend_nxt;
      hg_wait    <= wait_nxt;
      interval_q <= interval_nxt;
      hwy_q      <= hwy_nxt;
      farm_q     <= farm_nxt;
      walk_q     <= walk_nxt;
      expired_q  <= expired_nxt;
    end
  end

  assign bus.interval    = interval_q;
  assign bus.hwy_lights  = hwy_q;
  assign bus.farm_lights = farm_q;
  assign bus.walk        = walk_q;
  assign bus.expired     = expired_q;

endmodule
